// File: rtl/uart_pkg.sv
// Shared definitions for the UART sample link: state codes, frame geometry and a
// helper that sizes the fractional baud accumulator.
package uart_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StData  = 2'd2;
   localparam logic [1:0] StStop  = 2'd3;

   localparam int unsigned FrameBits = 10;
   localparam int unsigned DataBits  = 8;

   // Smallest width that holds acc + uartRate without wrapping (acc < slowRate).
   function automatic int unsigned min_acc_bits(input longint unsigned slow_rate,
                                                input longint unsigned uart_rate);
      return $unsigned($clog2(slow_rate + uart_rate + 1));
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud generator: a phase accumulator that emits one tick per bit period,
// averaging slowRate/uartRate cycles per tick with at most one cycle of jitter.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned slowRate = 76_800_000,
   parameter int unsigned uartRate = 12_000_000,
   parameter int unsigned accBits  = 32
) (
   input  logic clkSlow,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   if (accBits < min_acc_bits(slowRate, uartRate)) begin : g_acc_too_narrow
      $error("uart_baud_tick: accBits too narrow for slowRate + uartRate");
   end
   if (2 * longint'(uartRate) > longint'(slowRate)) begin : g_rate_too_high
      $error("uart_baud_tick: uartRate must be at most slowRate / 2");
   end

   localparam logic [accBits-1:0] Inc  = accBits'(uartRate);
   localparam logic [accBits-1:0] Wrap = accBits'(slowRate);

   logic [accBits-1:0] acc_q, acc_d, acc_sum;

   always_comb begin
      acc_sum = acc_q + Inc;
      tick    = enable && (acc_sum >= Wrap);
      acc_d   = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = tick ? (acc_sum - Wrap) : acc_sum;
      end
   end

   always_ff @(posedge clkSlow) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/uart_block_transmitter.sv
// Serialises one sample block into back-to-back 8N1 frames, byte 0 first and each
// byte LSB first, with line transitions only on baud ticks.
module uart_block_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned slowRate  = 76_800_000,
   parameter int unsigned uartRate  = 12_000_000,
   parameter int unsigned blockSize = 3,
   parameter int unsigned accBits   = 32
) (
   input  logic                   clkSlow,
   input  logic                   reset,
   input  logic [8*blockSize-1:0] data,
   input  logic                   valid,
   output logic                   ready,
   output logic                   uart,
   output logic                   busy
);

   localparam int unsigned BlockBits = DataBits * blockSize;
   localparam int unsigned ByteW     = (blockSize > 1) ? $clog2(blockSize) : 1;
   localparam logic [ByteW-1:0] LastByte = ByteW'(blockSize - 1);
   localparam logic [2:0]       LastBit  = 3'(DataBits - 1);

   logic [1:0]           state_q, state_d;
   logic [BlockBits-1:0] shift_q, shift_d;
   logic [2:0]           bit_q, bit_d;
   logic [ByteW-1:0]     byte_q, byte_d;
   logic                 uart_q, uart_d;
   logic                 busy_q;
   logic                 accept;
   logic                 tick;

   assign ready  = (state_q == StIdle) && !reset;
   assign accept = valid && ready;
   assign uart   = uart_q;
   assign busy   = busy_q;

   uart_baud_tick #(
      .slowRate(slowRate),
      .uartRate(uartRate),
      .accBits (accBits)
   ) u_baud (
      .clkSlow(clkSlow),
      .reset  (reset),
      .enable (state_q != StIdle),
      .clear  (accept),
      .tick   (tick)
   );

   // The whole block shifts as one register, so the next byte lands in [7:0] by itself.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      uart_d  = uart_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StStart;
               shift_d = data;
               bit_d   = '0;
               byte_d  = '0;
               uart_d  = 1'b0;
            end
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               uart_d  = shift_q[0];
            end
         end
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LastBit) begin
                  state_d = StStop;
                  bit_d   = '0;
                  uart_d  = 1'b1;
               end else begin
                  bit_d  = bit_q + 3'd1;
                  uart_d = shift_q[1];
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (byte_q == LastByte) begin
                  state_d = StIdle;
                  uart_d  = 1'b1;
               end else begin
                  state_d = StStart;
                  byte_d  = byte_q + ByteW'(1);
                  uart_d  = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clkSlow) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         uart_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         uart_q  <= uart_d;
         busy_q  <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_uart_block_transmitter.sv
// Bench for uart_block_transmitter: a line-level model compared every cycle, a bit-centre
// receiver that decodes the line, and directed scenarios with literal expectations.
module tb_uart_block_transmitter;

   localparam int unsigned SlowRate  = 76_800_000;
   localparam int unsigned UartRate  = 12_000_000;
   localparam int unsigned BlockSize = 3;
   localparam int unsigned AccBits   = 32;
   localparam int BlockCycles =
      int'((longint'(10 * BlockSize) * SlowRate + UartRate - 1) / UartRate);

   logic        clkSlow = 1'b0;
   logic        reset;
   logic [23:0] data;
   logic        valid;
   logic        ready;
   logic        uart;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_block_transmitter #(
      .slowRate (SlowRate),
      .uartRate (UartRate),
      .blockSize(BlockSize),
      .accBits  (AccBits)
   ) dut (
      .clkSlow(clkSlow),
      .reset  (reset),
      .data   (data),
      .valid  (valid),
      .ready  (ready),
      .uart   (uart),
      .busy   (busy)
   );

   always #5 clkSlow = ~clkSlow;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clkSlow);
      #2;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         cyc();
         n++;
      end
      check(name, busy, 0);
   endtask

   // ---------------- model: line level from elapsed cycles since accept ----------------
   bit          m_active = 1'b0;
   int          m_j      = 0;
   logic [23:0] m_blk    = '0;
   logic [7:0]  exp_bytes[$];

   // Frame bit k of the block: 10 bits per byte, start 0, data LSB first, stop 1.
   function automatic logic frame_bit(input logic [23:0] blk, input int k);
      int pos;
      int byt;
      pos = k % 10;
      byt = k / 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return blk[byt*8 + pos - 1];
   endfunction

   always @(posedge clkSlow) begin
      if (reset) begin
         m_active <= 1'b0;
         exp_bytes.delete();
      end else if (m_active) begin
         m_j <= m_j + 1;
         if (m_j + 1 >= BlockCycles) m_active <= 1'b0;
      end else if (valid) begin
         m_active <= 1'b1;
         m_j      <= 0;
         m_blk    <= data;
         for (int i = 0; i < 3; i++) exp_bytes.push_back(data[i*8 +: 8]);
      end
   end

   always @(negedge clkSlow) begin : cmp
      logic eu;
      int   k;
      eu = 1'b1;
      if (m_active) begin
         // Cycle j after the accept edge lies inside bit floor(j * uartRate / slowRate).
         k  = int'(longint'(m_j) * UartRate / SlowRate);
         eu = frame_bit(m_blk, k);
      end
      check("line", uart, eu);
      check("busy", busy, m_active);
      check("ready", ready, !m_active && !reset);
   end

   // ---------------- receiver: resync on each start edge, sample near bit centres ----------
   bit         rx_on   = 1'b0;
   int         rx_cnt  = 0;
   int         rx_b    = 0;
   logic [7:0] rx_sh   = '0;
   logic       rx_prev = 1'b1;
   logic [7:0] rx_log[$];

   always @(negedge clkSlow) begin : rx
      if (reset) begin
         rx_on <= 1'b0;
      end else if (!rx_on) begin
         if (rx_prev === 1'b1 && uart === 1'b0) begin
            rx_on  <= 1'b1;
            rx_cnt <= 1;
            rx_b   <= 0;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt == 3 + int'(longint'(rx_b) * SlowRate / UartRate)) begin
            rx_b <= rx_b + 1;
            if (rx_b == 0) begin
               check("rx_start", uart, 0);
            end else if (rx_b < 9) begin
               rx_sh <= {uart, rx_sh[7:1]};
            end else begin
               check("rx_stop", uart, 1);
               rx_on <= 1'b0;
               rx_log.push_back(rx_sh);
               if (exp_bytes.size() > 0) check("rx_byte", rx_sh, exp_bytes.pop_front());
               else check("rx_byte_expected", exp_bytes.size(), 1);
            end
         end
      end
      rx_prev <= uart;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int   n;
      int   base;
      int   rdy;
      int   s2;
      int   run;
      int   accepts;
      logic lvl;
      logic acc;
      int   runs[$];
      int   pat[5];
      logic trace[0:399];

      pat   = '{7, 6, 7, 6, 6};
      reset = 1'b1;
      valid = 1'b0;
      data  = '0;
      repeat (3) cyc();
      check("rst_ready", ready, 0);
      check("rst_uart", uart, 1);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      #1;
      check("rel_ready", ready, 1);
      cyc();

      // Single block: 3C, 5A, A5 on the line, 192 cycles of busy.
      base  = rx_log.size();
      data  = 24'hA55A3C;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      data  = '0;
      check("start_edge", uart, 0);
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         cyc();
         n++;
      end
      check("blk_len", n, 192);
      check("t1_byte0", rx_log[base], 8'h3C);
      check("t1_byte1", rx_log[base+1], 8'h5A);
      check("t1_byte2", rx_log[base+2], 8'hA5);
      cyc();

      // Baud pattern: 0x55 bytes alternate on every bit, so every run is one bit period.
      data  = 24'h555555;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      runs.delete();
      run = 1;
      lvl = uart;
      n   = 0;
      while (busy === 1'b1 && n < 1000) begin
         cyc();
         n++;
         if (uart !== lvl || busy !== 1'b1) begin
            runs.push_back(run);
            run = 1;
            lvl = uart;
         end else begin
            run++;
         end
      end
      check("baud_run_count", runs.size(), 30);
      for (int i = 0; i < runs.size() && i < 30; i++) check("baud_run", runs[i], pat[i%5]);
      cyc();

      // Back-to-back: valid held, second block queued right after the first accept.
      data  = 24'h123456;
      valid = 1'b1;
      cyc();
      data = 24'h89ABCD;
      rdy  = 0;
      for (int j = 0; j < 380; j++) begin
         trace[j] = uart;
         if (ready === 1'b1) rdy++;
         acc = (ready === 1'b1) && (valid === 1'b1);
         cyc();
         if (acc) valid = 1'b0;
      end
      s2 = -1;
      for (int j = 190; j < 380; j++) if (s2 < 0 && trace[j] === 1'b0) s2 = j;
      run = 0;
      if (s2 > 0) for (int j = s2 - 1; j >= 0 && trace[j] === 1'b1; j--) run++;
      check("b2b_gap_start", s2, 193);
      // Last stop bit (6 cycles) plus the single idle cycle in which block 2 is accepted.
      check("b2b_stop_run", run, 7);
      check("b2b_ready_cycles", rdy, 1);
      wait_idle("b2b_idle");
      cyc();

      // Reset 50 cycles into a frame, then an intact block.
      data  = 24'h0F1E2D;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      repeat (50) cyc();
      reset = 1'b1;
      cyc();
      check("mid_rst_uart", uart, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", ready, 0);
      reset = 1'b0;
      #1;
      check("mid_rel_ready", ready, 1);
      cyc();
      base  = rx_log.size();
      data  = 24'h5AA5F0;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      wait_idle("post_rst_idle");
      check("t4_byte0", rx_log[base], 8'hF0);
      check("t4_byte1", rx_log[base+1], 8'hA5);
      check("t4_byte2", rx_log[base+2], 8'h5A);
      cyc();

      // Handshake: valid held and data churning while busy; only the accepted block is sent.
      base    = rx_log.size();
      data    = 24'hC0FFEE;
      valid   = 1'b1;
      accepts = 0;
      for (int j = 0; j < 100; j++) begin
         if (ready === 1'b1 && valid === 1'b1) accepts++;
         cyc();
         data = 24'($urandom);
      end
      valid = 1'b0;
      check("hs_accepts", accepts, 1);
      wait_idle("hs_idle");
      check("t5_byte0", rx_log[base], 8'hEE);
      check("t5_byte1", rx_log[base+1], 8'hFF);
      check("t5_byte2", rx_log[base+2], 8'hC0);

      // Random blocks, offered at random points relative to the previous frame.
      for (int b = 0; b < 6; b++) begin
         data  = 24'($urandom);
         valid = 1'b1;
         n     = 0;
         while (ready !== 1'b1 && n < 500) begin
            cyc();
            n++;
         end
         cyc();
         valid = 1'b0;
         data  = 24'($urandom);
         repeat ($urandom_range(0, 80)) cyc();
      end
      wait_idle("rand_idle");
      repeat (70) cyc();
      check("rx_drain", exp_bytes.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_block_transmitter.md
# uart_block_transmitter

Serializes one audio sample block (blockSize bytes) into back-to-back 8N1 UART frames on the slow clock domain, at a fractional baud rate derived from a phase accumulator. It is the sending end of the same UART sample link the FM transmitter receives on. It is used for host loopback, for self-test benches driving the FM transmitter's `uart` input, and for telemetry out on `tx`.

## Interface
Parameters:
- `slowRate`, 76_800_000, clock frequency of `clkSlow` in Hz
- `uartRate`, 12_000_000, baud rate in Hz; must satisfy 2·uartRate ≤ slowRate
- `blockSize`, 3, bytes per sample block
- `accBits`, 32, baud accumulator width; must satisfy slowRate + uartRate < 2^accBits

Ports (one clock; reset is synchronous and active-high):
- `clkSlow`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `data`  in  8·blockSize  sample block; byte 0 = data[7:0]
- `valid`  in  1  block offered
- `ready`  out  1  block accepted when valid && ready
- `uart`  out  1  serial line, idle high
- `busy`  out  1  frame in progress

## Operation
- States: IDLE, START, DATA, STOP.
  - IDLE: `ready`=1 unless `reset`. On valid && ready, latch `data` into the shift register, clear the accumulator, set byte index = 0 and bit index = 0, then go to START.
  - START: `uart`=0.
  - DATA: `uart`=shift[0], LSB first. Shift right on each tick; after 8 ticks go to STOP.
  - STOP: `uart`=1. On tick, if byte index = blockSize−1 go to IDLE; otherwise increment the byte index and go to START. There is no idle gap between bytes.
- State transitions occur only on `tick`; the line level is held between ticks.
- Baud tick, per cycle while not IDLE:
  - if acc + uartRate ≥ slowRate: acc ← acc + uartRate − slowRate and tick=1
  - else: acc ← acc + uartRate and tick=0
  - acc is cleared on accept.
- Bit periods with the defaults repeat 7,6,7,6,6 cycles (32 cycles per 5 bits). Jitter is ≤1 cycle.
- `busy` = (state ≠ IDLE). `ready` = (state = IDLE) && !reset.
- `data` is sampled only in the accept cycle. Later changes to `data` and `valid` are ignored.

## Timing
- Reset values: state=IDLE, `uart`=1, `busy`=0, acc=0. `ready`=0 while `reset` is high and 1 in the cycle after it is released.
- `uart` and `busy` are registered. A falling start-bit edge appears on `uart` 1 cycle after the accept edge.
- Block duration is 10·blockSize bit periods. With the defaults that is 30 bits = 192 cycles from start-bit edge to return to IDLE.
- `ready` rises in the cycle after the final stop-bit tick. A new block can be accepted in that cycle, so the line shows exactly one stop-bit period between blocks.
- Reset mid-frame: at the next edge `uart`=1 and the FSM returns to IDLE. The partial frame is abandoned, not completed.
- valid held high while busy: no effect; the block is accepted at the next IDLE.
- blockSize=1: STOP goes straight to IDLE after one byte.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP}
  - constants: bits per frame = 10, data bits = 8
  - function computing the minimum accumulator width from slowRate and uartRate
- Sub-module `uart_baud_tick`:
  - ports `clkSlow`, `reset`, `enable`, `clear`, `tick`
  - parameters slowRate, uartRate, accBits
  - shared with the receive side for bit-centre sampling.
- Top FSM and shift register stay in `uart_block_transmitter`. Target is 150–250 lines total.

## Test plan
- Single block: data=24'hA55A3C, valid pulse.
  - Line sequence: start, 3C LSB-first (0,0,1,1,1,1,0,0), stop.
  - Then start, 5A LSB-first (0,1,0,1,1,0,1,0), stop.
  - Then start, A5 LSB-first (1,0,1,0,0,1,0,1), stop.
  - Return to IDLE after 192 cycles.
- Baud pattern: measure `uart` level durations across 0x55 bytes. Required: 7,6,7,6,6 repeating, averaging 6.4 cycles/bit.
- Back-to-back blocks: valid held high with two blocks queued by the bench.
  - Exactly one stop-bit period between the last stop of block 1 and the start of block 2.
  - `ready` is high for exactly 1 cycle between blocks.
- Reset mid-frame: assert reset at cycle 50 of a frame.
  - `uart`=1 and `busy`=0 at the next edge.
  - `ready`=1 the cycle after reset release.
  - The next block is transmitted intact.
- Handshake: valid held with changing `data` during busy. Only the value present at the accept edge is transmitted; no extra accept occurs while busy.
- Loopback: drive the FM transmitter's UART receiver with 100 random blocks. All received sample blocks match bit-exactly.
